// File: rtl/pio_irq_pkg.sv
// Shared types for the PIO interrupt master: FSM states and PIO register map.
// Level-read states exist only when PIO_IRQ_MASTER_LEVEL_EN is defined.
package pio_irq_pkg;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_MASK = 2'd2;
    localparam logic [1:0] REG_EDGE = 2'd3;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_RD_CAP,
        S_RD_WAIT,
        S_CLR,
`ifdef PIO_IRQ_MASTER_LEVEL_EN
        S_PUSH,
        S_RD_LVL,
        S_RD_LVL_WAIT
`else
        S_PUSH
`endif
    } state_t;

endpackage

// File: rtl/pio_irq_master.sv
// Avalon-MM master servicing an edge-capture PIO: read, clear, push event.
// Optional PIO_IRQ_MASTER_LEVEL_EN adds a data-register read (event_level).
module pio_irq_master
    import pio_irq_pkg::*;
#(
    parameter logic [7:0] IRQ_MASK = 8'hFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        irq,
    output logic [1:0]  address,
    output logic        chipselect,
    output logic        write_n,
    output logic [31:0] writedata,
    input  logic [31:0] readdata,
`ifdef PIO_IRQ_MASTER_LEVEL_EN
    output logic [7:0]  event_level,
`endif
    output logic [7:0]  event_data,
    output logic        event_valid,
    input  logic        event_ready
);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_cap;
    logic        w_cs;
    logic        w_wr_n;
    logic [1:0]  w_addr;
    logic [31:0] w_wdata;
    logic        w_evv;
    logic [7:0]  w_evd;
    logic        w_unused_rd;

    assign w_unused_rd = ^readdata[31:8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cap <= 8'h00;
        end else if (r_state == S_RD_WAIT) begin
            r_cap <= readdata[7:0] & IRQ_MASK;
        end
    end

`ifdef PIO_IRQ_MASTER_LEVEL_EN
    logic [7:0] r_level;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_level <= 8'h00;
        end else if (r_state == S_RD_LVL_WAIT) begin
            r_level <= readdata[7:0];
        end
    end

    assign event_level =
        (reset_n && r_state == S_PUSH) ? r_level : 8'h00;
`endif

    always_comb begin
        w_next  = r_state;
        w_cs    = 1'b0;
        w_wr_n  = 1'b1;
        w_addr  = REG_DATA;
        w_wdata = 32'h0;
        w_evv   = 1'b0;
        w_evd   = 8'h00;
        unique case (r_state)
            S_INIT: begin
                w_cs    = 1'b1;
                w_wr_n  = 1'b0;
                w_addr  = REG_MASK;
                w_wdata = {24'h0, IRQ_MASK};
                w_next  = S_IDLE;
            end
            S_IDLE: begin
                if (irq) w_next = S_RD_CAP;
            end
            S_RD_CAP: begin
                w_cs   = 1'b1;
                w_addr = REG_EDGE;
                w_next = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                w_addr = REG_EDGE;
                w_next = S_CLR;
            end
            S_CLR: begin
                w_cs    = 1'b1;
                w_wr_n  = 1'b0;
                w_addr  = REG_EDGE;
                w_wdata = {24'h0, r_cap};
`ifdef PIO_IRQ_MASTER_LEVEL_EN
                w_next  = (r_cap == 8'h00) ? S_IDLE : S_RD_LVL;
`else
                w_next  = (r_cap == 8'h00) ? S_IDLE : S_PUSH;
`endif
            end
`ifdef PIO_IRQ_MASTER_LEVEL_EN
            S_RD_LVL: begin
                w_cs   = 1'b1;
                w_addr = REG_DATA;
                w_next = S_RD_LVL_WAIT;
            end
            S_RD_LVL_WAIT: begin
                w_addr = REG_DATA;
                w_next = S_PUSH;
            end
`endif
            S_PUSH: begin
                w_evv = 1'b1;
                w_evd = r_cap;
                if (event_ready) w_next = S_IDLE;
            end
            default: w_next = S_INIT;
        endcase
    end

    // INIT is the reset state, so bus outputs are gated while reset is held
    assign chipselect  = reset_n & w_cs;
    assign write_n     = ~reset_n | w_wr_n;
    assign address     = reset_n ? w_addr : 2'd0;
    assign writedata   = reset_n ? w_wdata : 32'h0;
    assign event_valid = reset_n & w_evv;
    assign event_data  = reset_n ? w_evd : 8'h00;

endmodule

// File: tb/tb_pio_irq_master.sv
// Bench for pio_irq_master: PIO slave model plus bus/event scoreboard.
// Second instance with IRQ_MASK=8'h0F covers masked-out captures.
module tb_pio_irq_master;

    typedef struct packed {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
    } bus_t;

`ifdef PIO_IRQ_MASTER_LEVEL_EN
    localparam int EXP_LAT = 7;
    localparam logic [7:0] EXP_LVL = 8'hA3;
`else
    localparam int EXP_LAT = 5;
    localparam logic [7:0] EXP_LVL = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        irq;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata = 32'h0;
    logic [7:0]  event_data;
    logic        event_valid;
    logic        event_ready;
    logic [7:0]  event_level;

    logic        irq2;
    logic [1:0]  address2;
    logic        cs2;
    logic        wn2;
    logic [31:0] writedata2;
    logic [31:0] readdata2 = 32'h0;
    logic [7:0]  event_data2;
    logic        event_valid2;
    logic [7:0]  event_level2;

    int n_checks = 0;
    int n_fail = 0;

    bus_t        exp_bus[$];
    logic [15:0] exp_evt[$];
    bus_t        m_bus;
    logic [15:0] m_evt;
    logic [15:0] m_got;

    always #5 clk = ~clk;

    pio_irq_master u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .irq         (irq),
        .address     (address),
        .chipselect  (chipselect),
        .write_n     (write_n),
        .writedata   (writedata),
        .readdata    (readdata),
`ifdef PIO_IRQ_MASTER_LEVEL_EN
        .event_level (event_level),
`endif
        .event_data  (event_data),
        .event_valid (event_valid),
        .event_ready (event_ready)
    );

    pio_irq_master #(.IRQ_MASK(8'h0F)) u_dut2 (
        .clk         (clk),
        .reset_n     (reset_n),
        .irq         (irq2),
        .address     (address2),
        .chipselect  (cs2),
        .write_n     (wn2),
        .writedata   (writedata2),
        .readdata    (readdata2),
`ifdef PIO_IRQ_MASTER_LEVEL_EN
        .event_level (event_level2),
`endif
        .event_data  (event_data2),
        .event_valid (event_valid2),
        .event_ready (1'b1)
    );

`ifndef PIO_IRQ_MASTER_LEVEL_EN
    assign event_level  = 8'h00;
    assign event_level2 = 8'h00;
`endif

    // PIO slave models: registered read data, write-1-to-clear edge capture
    logic [7:0] s_edge = 8'h00, s_mask = 8'h00, s_inject = 8'h00;
    logic [7:0] s_data = 8'hA3;
    logic [7:0] s2_edge = 8'h00, s2_mask = 8'h00, s2_inject = 8'h00;

    always @(posedge clk) begin
        if (chipselect && write_n)
            readdata <= {24'h0,
                (address == 2'd0) ? s_data :
                (address == 2'd2) ? s_mask :
                (address == 2'd3) ? s_edge : 8'h00};
        if (chipselect && !write_n && address == 2'd2)
            s_mask <= writedata[7:0];
        s_edge <= (s_edge & ~((chipselect && !write_n && address == 2'd3)
                  ? writedata[7:0] : 8'h00)) | s_inject;
    end

    always @(posedge clk) begin
        if (cs2 && wn2)
            readdata2 <= {24'h0,
                (address2 == 2'd3) ? s2_edge :
                (address2 == 2'd2) ? s2_mask : 8'h00};
        if (cs2 && !wn2 && address2 == 2'd2)
            s2_mask <= writedata2[7:0];
        s2_edge <= (s2_edge & ~((cs2 && !wn2 && address2 == 2'd3)
                   ? writedata2[7:0] : 8'h00)) | s2_inject;
    end

    always @(negedge clk) begin
        if (chipselect) begin
            n_checks++;
            if (exp_bus.size() == 0) begin
                n_fail++;
                $display("FAIL bus_unexpected: got wr=%0b addr=%0d data=%h, required no access",
                         !write_n, address, writedata);
            end else begin
                m_bus = exp_bus.pop_front();
                if ({!write_n, address} !== {m_bus.wr, m_bus.addr} ||
                    (m_bus.wr && writedata !== m_bus.data)) begin
                    n_fail++;
                    $display("FAIL bus_op: got wr=%0b addr=%0d data=%h, required wr=%0b addr=%0d data=%h",
                             !write_n, address, writedata,
                             m_bus.wr, m_bus.addr, m_bus.data);
                end
            end
        end
        if (event_valid && event_ready) begin
            n_checks++;
            m_got = {event_level, event_data};
            if (exp_evt.size() == 0) begin
                n_fail++;
                $display("FAIL evt_unexpected: got %h, required none", m_got);
            end else begin
                m_evt = exp_evt.pop_front();
                if (m_got !== m_evt) begin
                    n_fail++;
                    $display("FAIL evt_data: got %h, required %h", m_got, m_evt);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_service(input logic [7:0] cap);
        exp_bus.push_back('{1'b0, 2'd3, 32'h0});
        exp_bus.push_back('{1'b1, 2'd3, {24'h0, cap}});
`ifdef PIO_IRQ_MASTER_LEVEL_EN
        exp_bus.push_back('{1'b0, 2'd0, 32'h0});
`endif
        exp_evt.push_back({EXP_LVL, cap});
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        irq = 1'b0;
        irq2 = 1'b0;
        event_ready = 1'b1;
        repeat (2) tick();
        n_checks++;
        if ({chipselect, write_n, address, writedata} !== {1'b0, 1'b1, 2'd0, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_bus: got cs=%0b wn=%0b a=%0d d=%h, required 0 1 0 0",
                     chipselect, write_n, address, writedata);
        end
        n_checks++;
        if ({event_valid, event_data} !== 9'h0) begin
            n_fail++;
            $display("FAIL reset_evt: got v=%0b d=%h, required 0 00", event_valid, event_data);
        end
        exp_bus.push_back('{1'b1, 2'd2, 32'h0000_00FF});
        reset_n = 1'b1;
        #1;
        n_checks++;
        if ({chipselect, write_n, address, writedata} !== {1'b1, 1'b0, 2'd2, 32'hFF}) begin
            n_fail++;
            $display("FAIL init_write: got cs=%0b wn=%0b a=%0d d=%h, required 1 0 2 000000ff",
                     chipselect, write_n, address, writedata);
        end
        repeat (6) tick();
        n_checks++;
        if (exp_bus.size() != 0) begin
            n_fail++;
            $display("FAIL init_pending: got %0d ops left, required 0", exp_bus.size());
        end
        n_checks++;
        if (s_mask !== 8'hFF || s2_mask !== 8'h0F) begin
            n_fail++;
            $display("FAIL slave_mask: got %h/%h, required ff/0f", s_mask, s2_mask);
        end
    endtask

    task automatic test_service();
        int lat;
        push_service(8'h05);
        s_inject = 8'h05;
        irq = 1'b1;
        lat = 1;
        tick();
        s_inject = 8'h00;
        irq = 1'b0;
        lat++;
        while (!event_valid && lat < 20) begin
            tick();
            lat++;
        end
        n_checks++;
        if (!event_valid || lat != EXP_LAT) begin
            n_fail++;
            $display("FAIL svc_latency: got v=%0b lat=%0d, required 1 %0d",
                     event_valid, lat, EXP_LAT);
        end
        n_checks++;
        if (event_data !== 8'h05 || event_level !== EXP_LVL) begin
            n_fail++;
            $display("FAIL svc_data: got %h lvl %h, required 05 lvl %h",
                     event_data, event_level, EXP_LVL);
        end
        repeat (4) tick();
        n_checks++;
        if (exp_bus.size() != 0 || exp_evt.size() != 0 || s_edge !== 8'h00) begin
            n_fail++;
            $display("FAIL svc_done: got bus=%0d evt=%0d edge=%h, required 0 0 00",
                     exp_bus.size(), exp_evt.size(), s_edge);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        event_ready = 1'b0;
        push_service(8'h3C);
        s_inject = 8'h3C;
        irq = 1'b1;
        tick();
        s_inject = 8'h00;
        n = 0;
        while (!event_valid && n < 20) begin
            tick();
            n++;
        end
        n_checks++;
        if (!event_valid) begin
            n_fail++;
            $display("FAIL b2b_timeout: got no event_valid, required 1");
        end
        s_inject = 8'h11;
        tick();
        s_inject = 8'h00;
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({event_valid, event_data, chipselect} !== {1'b1, 8'h3C, 1'b0}) begin
                n_fail++;
                $display("FAIL b2b_stall: got v=%0b d=%h cs=%0b, required 1 3c 0",
                         event_valid, event_data, chipselect);
            end
            tick();
        end
        push_service(8'h11);
        event_ready = 1'b1;
        tick();
        n_checks++;
        if (event_valid || chipselect) begin
            n_fail++;
            $display("FAIL b2b_idle: got v=%0b cs=%0b, required 0 0", event_valid, chipselect);
        end
        tick();
        n_checks++;
        if ({chipselect, write_n, address} !== {1'b1, 1'b1, 2'd3}) begin
            n_fail++;
            $display("FAIL b2b_restart: got cs=%0b wn=%0b a=%0d, required 1 1 3",
                     chipselect, write_n, address);
        end
        irq = 1'b0;
        n = 0;
        while (!event_valid && n < 20) begin
            tick();
            n++;
        end
        repeat (4) tick();
        n_checks++;
        if (exp_bus.size() != 0 || exp_evt.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_done: got bus=%0d evt=%0d, required 0 0",
                     exp_bus.size(), exp_evt.size());
        end
    endtask

    task automatic test_mask();
        int n;
        int seen_valid;
        seen_valid = 0;
        s2_inject = 8'hF0;
        irq2 = 1'b1;
        tick();
        s2_inject = 8'h00;
        n = 0;
        while (!(cs2 && !wn2 && address2 == 2'd3) && n < 20) begin
            if (event_valid2) seen_valid++;
            tick();
            n++;
        end
        n_checks++;
        if (!(cs2 && !wn2 && address2 == 2'd3) || writedata2 !== 32'h0) begin
            n_fail++;
            $display("FAIL mask_clr: got cs=%0b wn=%0b a=%0d d=%h, required 1 0 3 0",
                     cs2, wn2, address2, writedata2);
        end
        tick();
        n_checks++;
        if (cs2 || event_valid2) begin
            n_fail++;
            $display("FAIL mask_idle: got cs=%0b v=%0b, required 0 0", cs2, event_valid2);
        end
        tick();
        n_checks++;
        if ({cs2, wn2, address2} !== {1'b1, 1'b1, 2'd3}) begin
            n_fail++;
            $display("FAIL mask_rearm: got cs=%0b wn=%0b a=%0d, required 1 1 3",
                     cs2, wn2, address2);
        end
        irq2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (event_valid2) seen_valid++;
            tick();
        end
        n_checks++;
        if (seen_valid != 0 || s2_edge !== 8'hF0) begin
            n_fail++;
            $display("FAIL mask_noevt: got valid_cycles=%0d edge=%h, required 0 f0",
                     seen_valid, s2_edge);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        exp_bus.push_back('{1'b0, 2'd3, 32'h0});
        s_inject = 8'h42;
        irq = 1'b1;
        tick();
        s_inject = 8'h00;
        irq = 1'b0;
        n = 0;
        while (!(chipselect && !write_n && address == 2'd3) && n < 20) begin
            tick();
            n++;
        end
        n_checks++;
        if (!(chipselect && !write_n && address == 2'd3)) begin
            n_fail++;
            $display("FAIL rst_mid_clr: got cs=%0b wn=%0b a=%0d, required 1 0 3",
                     chipselect, write_n, address);
        end
        #1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({chipselect, write_n, address, writedata, event_valid, event_data}
            !== {1'b0, 1'b1, 2'd0, 32'h0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("FAIL rst_mid_out: got cs=%0b wn=%0b a=%0d d=%h v=%0b e=%h, required reset values",
                     chipselect, write_n, address, writedata, event_valid, event_data);
        end
        tick();
        exp_bus.push_back('{1'b1, 2'd2, 32'h0000_00FF});
        reset_n = 1'b1;
        #1;
        n_checks++;
        if ({chipselect, write_n, address, writedata} !== {1'b1, 1'b0, 2'd2, 32'hFF}) begin
            n_fail++;
            $display("FAIL rst_mid_init: got cs=%0b wn=%0b a=%0d d=%h, required 1 0 2 000000ff",
                     chipselect, write_n, address, writedata);
        end
        repeat (5) tick();
        n_checks++;
        if (exp_bus.size() != 0 || exp_evt.size() != 0 || event_valid) begin
            n_fail++;
            $display("FAIL rst_mid_done: got bus=%0d evt=%0d v=%0b, required 0 0 0",
                     exp_bus.size(), exp_evt.size(), event_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_service();
        test_back_to_back();
        test_mask();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
